// File: rtl/seq_alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu_pkg
//  Description : Shared opcode encodings and FSM state type for the
//                registered sequential ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_alu_pkg;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_AND  = 3'b001;
   localparam logic [2:0] OP_NOT  = 3'b010;
   localparam logic [2:0] OP_ZERO = 3'b011;
   localparam logic [2:0] OP_SUB  = 3'b100;
   localparam logic [2:0] OP_OR   = 3'b101;
   localparam logic [2:0] OP_XOR  = 3'b110;
   localparam logic [2:0] OP_MUL  = 3'b111;

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu_if
//  Description : Operand/opcode request and result/flag bundle of seq_alu.
//                master : drives IN1, IN2, CTRL, START; sees READY, DONE,
//                         OUT, CF, Z.
//                slave  : the ALU side of the same signals.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_alu_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] IN1;
   logic [WIDTH-1:0] IN2;
   logic [2:0]       CTRL;
   logic             START;
   logic             READY;
   logic             DONE;
   logic [WIDTH-1:0] OUT;
   logic             CF;
   logic             Z;

   modport master (
      output IN1, IN2, CTRL, START,
      input  READY, DONE, OUT, CF, Z
   );

   modport slave (
      input  IN1, IN2, CTRL, START,
      output READY, DONE, OUT, CF, Z
   );
endinterface
`default_nettype wire

// File: rtl/seq_alu_mul.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu_mul
//  Description : Shift-add multiplier, one partial product per step, LSB of
//                the multiplier first.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                start           - latch operands, clear product
//                step            - perform one shift-add step
//                a, b            - multiplicand, multiplier
//                product_next    - product including the current step
//                last            - current step is the final one
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu_mul #(
   parameter int WIDTH = 8
) (
   input  wire logic                 clk,
   input  wire logic                 rst,
   input  wire logic                 start,
   input  wire logic                 step,
   input  wire logic [WIDTH-1:0]     a,
   input  wire logic [WIDTH-1:0]     b,
   output logic      [2*WIDTH-1:0]   product_next,
   output logic                      last
);
   localparam int              CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0]   CNT_INIT = CW'(WIDTH - 1);

   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplr_q,  mplr_d;
   logic [2*WIDTH-1:0] prod_q,  prod_d;
   logic [CW-1:0]      cnt_q,   cnt_d;

   // Exposing the post-step product lets the top capture the result on the
   // same edge as the final step instead of one cycle later.
   assign product_next = prod_q + (mplr_q[0] ? mcand_q : '0);
   assign last         = step && (cnt_q == '0);

   always_comb begin
      mcand_d = mcand_q;
      mplr_d  = mplr_q;
      prod_d  = prod_q;
      cnt_d   = cnt_q;
      if (start) begin
         mcand_d = {{WIDTH{1'b0}}, a};
         mplr_d  = b;
         prod_d  = '0;
         cnt_d   = CNT_INIT;
      end else if (step) begin
         prod_d  = product_next;
         mcand_d = mcand_q << 1;
         mplr_d  = mplr_q >> 1;
         cnt_d   = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mcand_q <= '0;
         mplr_q  <= '0;
         prod_q  <= '0;
         cnt_q   <= '0;
      end else begin
         mcand_q <= mcand_d;
         mplr_q  <= mplr_d;
         prod_q  <= prod_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : seq_alu
//  Description : Registered WIDTH-bit ALU with START/READY/DONE handshake.
//                Seven single-cycle ops plus a WIDTH-step multiply.
//  Ports       : CLK  - clock
//                RST  - synchronous active-high reset
//                bus  - seq_alu_if.slave (IN1, IN2, CTRL, START in;
//                       READY, DONE, OUT, CF, Z out, all registered)
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_alu
   import seq_alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  wire logic CLK,
   input  wire logic RST,
   seq_alu_if.slave  bus
);
   state_t           state_q, state_d;
   logic [WIDTH-1:0] out_q,   out_d;
   logic             cf_q,    cf_d;
   logic             z_q,     z_d;
   logic             done_q,  done_d;

   logic [WIDTH-1:0]   alu_res;
   logic               alu_cf;
   logic               mul_start;
   logic               mul_step;
   logic               mul_last;
   logic [2*WIDTH-1:0] mul_prod;

   assign mul_step = (state_q == S_MUL);

   seq_alu_mul #(.WIDTH(WIDTH)) u_mul (
      .clk          (CLK),
      .rst          (RST),
      .start        (mul_start),
      .step         (mul_step),
      .a            (bus.IN1),
      .b            (bus.IN2),
      .product_next (mul_prod),
      .last         (mul_last)
   );

   // Single-cycle result mux; the extra top bit of ADD/SUB is carry/borrow.
   always_comb begin
      alu_res = '0;
      alu_cf  = 1'b0;
      case (bus.CTRL)
         OP_ADD:  {alu_cf, alu_res} = {1'b0, bus.IN1} + {1'b0, bus.IN2};
         OP_SUB:  {alu_cf, alu_res} = {1'b0, bus.IN1} - {1'b0, bus.IN2};
         OP_AND:  alu_res = bus.IN1 & bus.IN2;
         OP_OR:   alu_res = bus.IN1 | bus.IN2;
         OP_XOR:  alu_res = bus.IN1 ^ bus.IN2;
         OP_NOT:  alu_res = ~bus.IN1;
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      cf_d      = cf_q;
      z_d       = z_q;
      done_d    = 1'b0;
      mul_start = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.START) begin
               if (bus.CTRL == OP_MUL) begin
                  mul_start = 1'b1;
                  state_d   = S_MUL;
               end else begin
                  out_d  = alu_res;
                  cf_d   = alu_cf;
                  z_d    = (alu_res == '0);
                  done_d = 1'b1;
               end
            end
         end
         S_MUL: begin
            if (mul_last) begin
               out_d   = mul_prod[WIDTH-1:0];
               cf_d    = |mul_prod[2*WIDTH-1:WIDTH];
               z_d     = (mul_prod[WIDTH-1:0] == '0);
               done_d  = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         out_q   <= '0;
         cf_q    <= 1'b0;
         z_q     <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         cf_q    <= cf_d;
         z_q     <= z_d;
         done_q  <= done_d;
      end
   end

   assign bus.READY = (state_q == S_IDLE);
   assign bus.DONE  = done_q;
   assign bus.OUT   = out_q;
   assign bus.CF    = cf_q;
   assign bus.Z     = z_q;
endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_alu
//  Description : Directed self-checking bench for seq_alu (WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_alu;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;

   seq_alu_if #(.WIDTH(W)) bus ();

   seq_alu #(.WIDTH(W)) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   // Inputs change and outputs are sampled on the falling edge.
   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bus.CTRL  = op;
      bus.IN1   = a;
      bus.IN2   = b;
      bus.START = 1'b1;
      @(negedge clk);
      bus.START = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.START = 1'b1; bus.CTRL = 3'b000; bus.IN1 = 8'd1; bus.IN2 = 8'd1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      bus.START = 1'b0;
      n_cmp++; if (bus.READY !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", bus.READY); end
      n_cmp++; if (bus.DONE !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.DONE); end
      n_cmp++; if ({bus.OUT, bus.CF, bus.Z} !== 10'd0) begin n_bad++; $display("FAIL reset_out got %h/%b/%b want 00/0/0", bus.OUT, bus.CF, bus.Z); end
      @(negedge clk);
      n_cmp++; if (bus.DONE !== 1'b0 || bus.OUT !== 8'd0) begin n_bad++; $display("FAIL start_with_rst got done=%b out=%h want 0/00", bus.DONE, bus.OUT); end
   endtask

   task automatic test_add();
      @(negedge clk);
      issue(3'b000, 8'd200, 8'd100);
      n_cmp++; if ({bus.DONE, bus.OUT, bus.CF, bus.Z} !== {1'b1, 8'd44, 1'b1, 1'b0}) begin n_bad++;
         $display("FAIL add got done=%b out=%0d cf=%b z=%b want 1/44/1/0", bus.DONE, bus.OUT, bus.CF, bus.Z); end
      @(negedge clk);
      n_cmp++; if (bus.DONE !== 1'b0) begin n_bad++; $display("FAIL add_done_pulse got %b want 0", bus.DONE); end
   endtask

   task automatic test_logic_ops();
      logic [2:0] ops [4] = '{3'b001, 3'b101, 3'b010, 3'b011};
      logic [7:0] exp [4] = '{8'h88, 8'hEE, 8'h33, 8'h00};
      for (int i = 0; i < 4; i++) begin
         issue(ops[i], 8'hCC, 8'hAA);
         n_cmp++; if ({bus.DONE, bus.OUT, bus.CF, bus.Z} !== {1'b1, exp[i], 1'b0, (exp[i] == 8'h00)}) begin n_bad++;
            $display("FAIL logic_op%0d got done=%b out=%h cf=%b z=%b want out=%h", i, bus.DONE, bus.OUT, bus.CF, bus.Z, exp[i]); end
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      bus.CTRL = 3'b100; bus.IN1 = 8'd5; bus.IN2 = 8'd7; bus.START = 1'b1;
      @(negedge clk);
      n_cmp++; if ({bus.DONE, bus.OUT, bus.CF, bus.Z} !== {1'b1, 8'd254, 1'b1, 1'b0}) begin n_bad++;
         $display("FAIL sub_borrow got done=%b out=%0d cf=%b z=%b want 1/254/1/0", bus.DONE, bus.OUT, bus.CF, bus.Z); end
      bus.IN1 = 8'd7;
      @(negedge clk);
      bus.START = 1'b0;
      n_cmp++; if ({bus.DONE, bus.OUT, bus.CF, bus.Z} !== {1'b1, 8'd0, 1'b0, 1'b1}) begin n_bad++;
         $display("FAIL sub_zero got done=%b out=%0d cf=%b z=%b want 1/0/0/1", bus.DONE, bus.OUT, bus.CF, bus.Z); end
      @(negedge clk);
      n_cmp++; if (bus.DONE !== 1'b0) begin n_bad++; $display("FAIL b2b_done_end got %b want 0", bus.DONE); end
   endtask

   task automatic test_mul(input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] e_out, input logic e_cf, input logic e_z);
      int busy = 0;
      bit seen = 0;
      issue(3'b111, a, b);
      for (int i = 0; i < 20 && !seen; i++) begin
         if (bus.DONE === 1'b1) seen = 1;
         else begin
            if (bus.READY === 1'b0) busy++;
            @(negedge clk);
         end
      end
      n_cmp++; if (!seen) begin n_bad++; $display("FAIL mul_timeout got no DONE want DONE within 20 cycles"); end
      n_cmp++; if (busy != 8) begin n_bad++; $display("FAIL mul_busy_cycles got %0d want 8", busy); end
      n_cmp++; if ({bus.READY, bus.OUT, bus.CF, bus.Z} !== {1'b1, e_out, e_cf, e_z}) begin n_bad++;
         $display("FAIL mul_%0d_%0d got rdy=%b out=%0d cf=%b z=%b want 1/%0d/%b/%b", a, b, bus.READY, bus.OUT, bus.CF, bus.Z, e_out, e_cf, e_z); end
      @(negedge clk);
   endtask

   task automatic test_start_while_busy();
      int dones = 0;
      issue(3'b111, 8'd3, 8'd5);
      issue(3'b000, 8'd1, 8'd1);
      for (int i = 0; i < 15; i++) begin
         if (bus.DONE === 1'b1) begin
            dones++;
            n_cmp++; if (bus.OUT !== 8'd15 || bus.CF !== 1'b0) begin n_bad++;
               $display("FAIL busy_mul_result got out=%0d cf=%b want 15/0", bus.OUT, bus.CF); end
         end
         @(negedge clk);
      end
      n_cmp++; if (dones != 1) begin n_bad++; $display("FAIL busy_done_count got %0d want 1", dones); end
   endtask

   task automatic test_rst_during_mul();
      int dones = 0;
      issue(3'b111, 8'd200, 8'd3);
      repeat (3) @(negedge clk);
      n_cmp++; if (bus.READY !== 1'b0) begin n_bad++; $display("FAIL abort_busy got ready=%b want 0", bus.READY); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++; if ({bus.READY, bus.DONE, bus.OUT, bus.CF, bus.Z} !== {1'b1, 1'b0, 8'd0, 1'b0, 1'b0}) begin n_bad++;
         $display("FAIL abort_state got rdy=%b done=%b out=%0d cf=%b z=%b want 1/0/0/0/0", bus.READY, bus.DONE, bus.OUT, bus.CF, bus.Z); end
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.DONE === 1'b1) dones++;
      end
      n_cmp++; if (dones != 0) begin n_bad++; $display("FAIL abort_no_done got %0d DONE pulses want 0", dones); end
   endtask

   task automatic test_hold();
      issue(3'b110, 8'hF0, 8'h0F);
      n_cmp++; if ({bus.DONE, bus.OUT, bus.CF, bus.Z} !== {1'b1, 8'hFF, 1'b0, 1'b0}) begin n_bad++;
         $display("FAIL xor got done=%b out=%h cf=%b z=%b want 1/ff/0/0", bus.DONE, bus.OUT, bus.CF, bus.Z); end
      bus.IN1 = 8'h00; bus.IN2 = 8'h00; bus.CTRL = 3'b011;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         n_cmp++; if ({bus.DONE, bus.OUT, bus.CF, bus.Z} !== {1'b0, 8'hFF, 1'b0, 1'b0}) begin n_bad++;
            $display("FAIL hold_%0d got done=%b out=%h cf=%b z=%b want 0/ff/0/0", i, bus.DONE, bus.OUT, bus.CF, bus.Z); end
      end
   endtask

   initial begin
      bus.START = 1'b0; bus.CTRL = 3'b000; bus.IN1 = '0; bus.IN2 = '0;
      @(negedge clk);
      test_reset();
      test_add();
      test_logic_ops();
      test_back_to_back();
      test_mul(8'd16, 8'd16, 8'd0, 1'b1, 1'b1);
      test_mul(8'd15, 8'd17, 8'd255, 1'b0, 1'b0);
      test_start_while_busy();
      test_rst_during_mul();
      test_hold();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/seq_alu.md
# seq_alu

Parametrised, registered ALU: successor to the 4-bit combinational ALU. Supports WIDTH-bit operands, eight operations (including subtract and a multi-cycle shift-add multiply), a START/READY/DONE handshake, and registered OUT/CF/Z that hold between operations. It sits between the operand/control switch logic and the display/flag outputs of the datapath, and replaces the TOGGLE-gated combinational select.

## Interface
Parameters:
- WIDTH, 8, operand and result width; legal range is 2 or more.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST  in  1  synchronous reset, active-high. One clock; reset is synchronous and active-high.
- IN1  in  WIDTH  operand A; sampled only on the accept edge.
- IN2  in  WIDTH  operand B; sampled only on the accept edge.
- CTRL  in  3  opcode; sampled on the accept edge.
  - 000 ADD, 001 AND, 010 NOT (of IN1), 011 ZERO
  - 100 SUB (IN1-IN2), 101 OR, 110 XOR, 111 MUL
- START  in  1  operation request; accepted when START and READY are both 1 at an edge.
- READY  out  1  block can accept; reset value 1.
- DONE  out  1  one-cycle pulse: OUT/CF/Z were just updated; reset value 0.
- OUT  out  WIDTH  registered result; reset value 0.
- CF  out  1  registered carry/borrow/overflow flag; reset value 0.
- Z  out  1  registered zero flag; reset value 0.

## Operation
- FSM states:
  - IDLE: READY=1.
  - MUL: READY=0; iteration counter runs from WIDTH-1 down to 0.
- IDLE, accept with op other than MUL: at the accept edge, write OUT/CF/Z and set DONE=1 for the following cycle. Stay in IDLE.
- IDLE, accept MUL:
  - Latch operands. Clear the 2*WIDTH-bit product register. Go to MUL.
  - Each edge performs one shift-add step, LSB of the multiplier first.
  - On the WIDTH-th step edge:
    - OUT = product[WIDTH-1:0].
    - CF = OR of product[2*WIDTH-1:WIDTH].
    - DONE=1 for the following cycle.
    - Return to IDLE.
- Flag rules. All arithmetic is unsigned, modulo 2^WIDTH.
  - ADD: CF = carry out of bit WIDTH-1.
  - SUB: CF = borrow, i.e. 1 when IN1<IN2.
  - MUL: CF = high half non-zero.
  - AND/OR/XOR/NOT/ZERO: CF=0.
  - Z = (OUT==0) for every op.
  - ZERO: OUT=0, Z=1, CF=0.
- Hold: when no completion occurs, OUT/CF/Z keep their last values. DONE is 0 except in the single cycle after a completion.
- START while READY=0 is ignored. It is not queued.
- IN1/IN2/CTRL changes during MUL have no effect.
- RST wins over everything:
  - A START in the same cycle as RST is dropped.
  - RST during MUL aborts the operation: FSM to IDLE, all outputs to reset values, no DONE.

## Timing
- Single-cycle ops: accept at edge k. OUT/CF/Z/DONE are valid in cycle k+1. READY stays 1, so back-to-back accepts every cycle give one DONE per cycle.
- MUL: accept at edge k.
  - READY=0 in cycles k+1 .. k+WIDTH.
  - Final step at edge k+WIDTH. DONE=1 and READY=1 in cycle k+WIDTH+1.
  - A new START in the DONE cycle is accepted.
- No combinational path from any input to any output. READY and DONE are decoded from registered state.

## Structure
- Package seq_alu_pkg holds:
  - opcode localparams (OP_ADD .. OP_MUL, 3 bits);
  - the FSM state enum (S_IDLE, S_MUL).
- Sub-module seq_alu_mul contains the shift-add multiplier:
  - product and counter registers;
  - start, step and last signals.
- The top level holds the FSM, the single-cycle op mux, and the output/flag registers.

## Test plan
- WIDTH=8, ADD 200+100 -> next cycle OUT=44, CF=1, Z=0, DONE=1 for exactly 1 cycle.
- SUB 5-7 -> OUT=254, CF=1, Z=0. Then SUB 7-7 on the next cycle -> OUT=0, CF=0, Z=1 (back-to-back, two DONE pulses).
- MUL 16*16 -> READY=0 for 8 cycles, then OUT=0, CF=1, Z=1, DONE. MUL 15*17 -> OUT=255, CF=0, Z=0.
- START ADD 1+1 pulsed while MUL 3*5 is busy -> ignored. Only one DONE, with OUT=15, CF=0.
- RST asserted at cycle 4 of MUL 200*3 -> next cycle OUT=0, CF=0, Z=0, READY=1, and no DONE afterwards.
- No START for 10 cycles after XOR 0xF0^0x0F -> OUT=0xFF, CF=0, Z=0 held constant and DONE stays 0.
